// File: rtl/data_mem_arbiter_if.sv
// Request/response bundle between the per-thread LSU slots, the arbiter and
// the external data-memory channels.
interface data_mem_arbiter_if #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1
);
   // Consumer (LSU) side
   logic [NUM_CONSUMERS-1:0] consumer_read_valid;
   logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS];
   logic [NUM_CONSUMERS-1:0] consumer_read_ready;
   logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS];
   logic [NUM_CONSUMERS-1:0] consumer_write_valid;
   logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS];
   logic [NUM_CONSUMERS-1:0] consumer_write_ready;

   // Memory channel side
   logic [NUM_CHANNELS-1:0]  mem_read_valid;
   logic [ADDR_BITS-1:0]     mem_read_address  [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]  mem_read_ready;
   logic [DATA_BITS-1:0]     mem_read_data     [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]  mem_write_valid;
   logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     mem_write_data    [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]  mem_write_ready;

   // Arbiter view
   modport slave (
      input  consumer_read_valid, consumer_read_address,
      output consumer_read_ready, consumer_read_data,
      input  consumer_write_valid, consumer_write_address, consumer_write_data,
      output consumer_write_ready,
      output mem_read_valid, mem_read_address,
      input  mem_read_ready, mem_read_data,
      output mem_write_valid, mem_write_address, mem_write_data,
      input  mem_write_ready
   );

   // LSU / memory environment view
   modport master (
      output consumer_read_valid, consumer_read_address,
      input  consumer_read_ready, consumer_read_data,
      output consumer_write_valid, consumer_write_address, consumer_write_data,
      input  consumer_write_ready,
      input  mem_read_valid, mem_read_address,
      output mem_read_ready, mem_read_data,
      input  mem_write_valid, mem_write_address, mem_write_data,
      output mem_write_ready
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Per-thread LSU request arbiter: each memory channel runs its own request
// FSM with a round-robin pointer; a claim bit per consumer keeps any consumer
// from being served by two channels at once. All outputs are registered.
module data_mem_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1
) (
   input  logic               clk,
   input  logic               reset,
   data_mem_arbiter_if.slave  bus
);
   localparam int IDW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      READ_WAITING  = 3'd1,
      WRITE_WAITING = 3'd2,
      READ_RELAY    = 3'd3,
      WRITE_RELAY   = 3'd4
   } state_t;

   state_t                   state_r [NUM_CHANNELS];
   state_t                   state_nx[NUM_CHANNELS];
   logic [IDW-1:0]           id_r    [NUM_CHANNELS];
   logic [IDW-1:0]           id_nx   [NUM_CHANNELS];
   logic [IDW-1:0]           rr_r    [NUM_CHANNELS];
   logic [IDW-1:0]           rr_nx   [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] claimed_r, claimed_nx;

   logic [NUM_CHANNELS-1:0]  mrv_r, mrv_nx, mwv_r, mwv_nx;
   logic [ADDR_BITS-1:0]     mra_r [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     mra_nx[NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     mwa_r [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     mwa_nx[NUM_CHANNELS];
   logic [DATA_BITS-1:0]     mwd_r [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     mwd_nx[NUM_CHANNELS];

   logic [NUM_CONSUMERS-1:0] crr_r, crr_nx, cwr_r, cwr_nx;
   logic [DATA_BITS-1:0]     crd_r [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]     crd_nx[NUM_CONSUMERS];

   // Next-state and next-output logic; channels are evaluated in index order so
   // a lower channel's grant this cycle hides that consumer from higher ones.
   always_comb begin
      logic [NUM_CONSUMERS-1:0] taken;
      logic                     found;
      logic [IDW-1:0]           cand;
      state_nx   = state_r;
      id_nx      = id_r;
      rr_nx      = rr_r;
      claimed_nx = claimed_r;
      mrv_nx     = mrv_r;
      mra_nx     = mra_r;
      mwv_nx     = mwv_r;
      mwa_nx     = mwa_r;
      mwd_nx     = mwd_r;
      crr_nx     = crr_r;
      cwr_nx     = cwr_r;
      crd_nx     = crd_r;
      taken      = claimed_r;
      found      = 1'b0;
      cand       = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         case (state_r[c])
            IDLE: begin
               found = 1'b0;
               cand  = '0;
               for (int k = 0; k < NUM_CONSUMERS; k++) begin
                  if (!found) begin
                     cand = IDW'((int'(rr_r[c]) + k) % NUM_CONSUMERS);
                     if (!taken[cand] &&
                         (bus.consumer_read_valid[cand] || bus.consumer_write_valid[cand]))
                        found = 1'b1;
                  end
               end
               if (found) begin
                  taken[cand]      = 1'b1;
                  claimed_nx[cand] = 1'b1;
                  id_nx[c]         = cand;
                  rr_nx[c]         = IDW'((int'(cand) + 1) % NUM_CONSUMERS);
                  if (bus.consumer_read_valid[cand]) begin
                     mrv_nx[c]   = 1'b1;
                     mra_nx[c]   = bus.consumer_read_address[cand];
                     state_nx[c] = READ_WAITING;
                  end else begin
                     mwv_nx[c]   = 1'b1;
                     mwa_nx[c]   = bus.consumer_write_address[cand];
                     mwd_nx[c]   = bus.consumer_write_data[cand];
                     state_nx[c] = WRITE_WAITING;
                  end
               end
            end
            READ_WAITING: begin
               if (bus.mem_read_ready[c]) begin
                  mrv_nx[c]         = 1'b0;
                  crd_nx[id_r[c]]   = bus.mem_read_data[c];
                  crr_nx[id_r[c]]   = 1'b1;
                  state_nx[c]       = READ_RELAY;
               end
            end
            WRITE_WAITING: begin
               if (bus.mem_write_ready[c]) begin
                  mwv_nx[c]         = 1'b0;
                  cwr_nx[id_r[c]]   = 1'b1;
                  state_nx[c]       = WRITE_RELAY;
               end
            end
            READ_RELAY: begin
               if (!bus.consumer_read_valid[id_r[c]]) begin
                  crr_nx[id_r[c]]     = 1'b0;
                  claimed_nx[id_r[c]] = 1'b0;
                  state_nx[c]         = IDLE;
               end
            end
            WRITE_RELAY: begin
               if (!bus.consumer_write_valid[id_r[c]]) begin
                  cwr_nx[id_r[c]]     = 1'b0;
                  claimed_nx[id_r[c]] = 1'b0;
                  state_nx[c]         = IDLE;
               end
            end
            default: state_nx[c] = IDLE;
         endcase
      end
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_r[c] <= IDLE;
            id_r[c]    <= '0;
            rr_r[c]    <= '0;
            mra_r[c]   <= '0;
            mwa_r[c]   <= '0;
            mwd_r[c]   <= '0;
         end
         for (int i = 0; i < NUM_CONSUMERS; i++) crd_r[i] <= '0;
         claimed_r <= '0;
         mrv_r     <= '0;
         mwv_r     <= '0;
         crr_r     <= '0;
         cwr_r     <= '0;
      end else begin
         state_r   <= state_nx;
         id_r      <= id_nx;
         rr_r      <= rr_nx;
         mra_r     <= mra_nx;
         mwa_r     <= mwa_nx;
         mwd_r     <= mwd_nx;
         crd_r     <= crd_nx;
         claimed_r <= claimed_nx;
         mrv_r     <= mrv_nx;
         mwv_r     <= mwv_nx;
         crr_r     <= crr_nx;
         cwr_r     <= cwr_nx;
      end
   end

   assign bus.mem_read_valid       = mrv_r;
   assign bus.mem_read_address     = mra_r;
   assign bus.mem_write_valid      = mwv_r;
   assign bus.mem_write_address    = mwa_r;
   assign bus.mem_write_data       = mwd_r;
   assign bus.consumer_read_ready  = crr_r;
   assign bus.consumer_read_data   = crd_r;
   assign bus.consumer_write_ready = cwr_r;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a one-channel and a two-channel instance, each
// backed by a memory responder, checked against a plain array memory model.
module tb_data_mem_arbiter;
   localparam int AB = 8;
   localparam int DB = 8;
   localparam int NC = 4;

   logic clk;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   lat1   = 0;   // responder latency in cycles of valid; -1 = random
   int   lat2   = 0;

   logic [7:0] phys_mem1 [256];
   logic [7:0] phys_mem2 [256];
   logic [7:0] exp_mem1  [256];
   logic [7:0] exp_mem2  [256];

   data_mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) bus1 ();
   data_mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(2)) bus2 ();

   data_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) u_dut1 (
      .clk(clk), .reset(reset), .bus(bus1));
   data_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(2)) u_dut2 (
      .clk(clk), .reset(reset), .bus(bus2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory responder for the one-channel instance
   initial begin : resp1
      int rc, wc;
      rc = 0; wc = 0;
      bus1.mem_read_ready  = '0;
      bus1.mem_write_ready = '0;
      bus1.mem_read_data[0] = '0;
      forever begin
         tick();
         bus1.mem_read_ready[0]  = 1'b0;
         bus1.mem_write_ready[0] = 1'b0;
         if (bus1.mem_read_valid[0]) begin
            if ((lat1 >= 0) ? (rc >= lat1) : ($urandom_range(0, 1) == 0)) begin
               bus1.mem_read_ready[0] = 1'b1;
               bus1.mem_read_data[0]  = phys_mem1[bus1.mem_read_address[0]];
            end
            rc++;
         end else rc = 0;
         if (bus1.mem_write_valid[0]) begin
            if ((lat1 >= 0) ? (wc >= lat1) : ($urandom_range(0, 1) == 0)) begin
               bus1.mem_write_ready[0] = 1'b1;
               phys_mem1[bus1.mem_write_address[0]] = bus1.mem_write_data[0];
            end
            wc++;
         end else wc = 0;
      end
   end

   // Memory responder for the two-channel instance
   initial begin : resp2
      int rc [2];
      int wc [2];
      for (int c = 0; c < 2; c++) begin
         rc[c] = 0; wc[c] = 0;
         bus2.mem_read_data[c] = '0;
      end
      bus2.mem_read_ready  = '0;
      bus2.mem_write_ready = '0;
      forever begin
         tick();
         for (int c = 0; c < 2; c++) begin
            bus2.mem_read_ready[c]  = 1'b0;
            bus2.mem_write_ready[c] = 1'b0;
            if (bus2.mem_read_valid[c]) begin
               if ((lat2 >= 0) ? (rc[c] >= lat2) : ($urandom_range(0, 1) == 0)) begin
                  bus2.mem_read_ready[c] = 1'b1;
                  bus2.mem_read_data[c]  = phys_mem2[bus2.mem_read_address[c]];
               end
               rc[c]++;
            end else rc[c] = 0;
            if (bus2.mem_write_valid[c]) begin
               if ((lat2 >= 0) ? (wc[c] >= lat2) : ($urandom_range(0, 1) == 0)) begin
                  bus2.mem_write_ready[c] = 1'b1;
                  phys_mem2[bus2.mem_write_address[c]] = bus2.mem_write_data[c];
               end
               wc[c]++;
            end else wc[c] = 0;
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0;
      tick(); tick();
      n_cmp++; if (bus1.mem_read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", bus1.mem_read_valid); end
      n_cmp++; if (bus1.mem_write_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", bus1.mem_write_valid); end
      n_cmp++; if (bus2.mem_read_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rd_valid2: got %b want 0", bus2.mem_read_valid); end
      n_cmp++; if ((bus1.consumer_read_ready | bus1.consumer_write_ready) !== 4'h0) begin n_fail++; $display("FAIL reset_cons_ready: got %h want 0", bus1.consumer_read_ready | bus1.consumer_write_ready); end
      reset = 1'b1;
      tick();
      lat1 = 100;
      bus1.consumer_read_address[0] = 8'h55;
      bus1.consumer_read_valid[0]   = 1'b1;
      tick();
      n_cmp++; if (bus1.mem_read_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_grant: got %b want 1", bus1.mem_read_valid); end
      tick();
      // Mid READ_WAITING: reset must clear outputs without waiting for a clock edge
      reset = 1'b0;
      #1;
      n_cmp++; if (bus1.mem_read_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", bus1.mem_read_valid); end
      n_cmp++; if (bus1.mem_read_address[0] !== 8'h00) begin n_fail++; $display("FAIL async_reset_addr: got %h want 00", bus1.mem_read_address[0]); end
      bus1.consumer_read_valid[0] = 1'b0;
      tick();
      reset = 1'b1;
      lat1 = 0;
      tick();
      n_cmp++; if (bus1.mem_read_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", bus1.mem_read_valid); end
      bus1.consumer_read_valid[0] = 1'b1;
      tick();
      n_cmp++; if (bus1.mem_read_valid !== 1'b1 || bus1.mem_read_address[0] !== 8'h55) begin n_fail++; $display("FAIL post_reset_req: got v=%b a=%h want v=1 a=55", bus1.mem_read_valid, bus1.mem_read_address[0]); end
      tick();
      n_cmp++; if (bus1.consumer_read_ready !== 4'b0001 || bus1.consumer_read_data[0] !== exp_mem1[8'h55]) begin n_fail++; $display("FAIL post_reset_data: got r=%b d=%h want r=0001 d=%h", bus1.consumer_read_ready, bus1.consumer_read_data[0], exp_mem1[8'h55]); end
      bus1.consumer_read_valid[0] = 1'b0;
      tick();
      n_cmp++; if (bus1.consumer_read_ready !== 4'b0000) begin n_fail++; $display("FAIL post_reset_release: got %b want 0000", bus1.consumer_read_ready); end
   endtask

   task automatic test_single_read();
      phys_mem1[8'h3C] = 8'hA5;
      exp_mem1[8'h3C]  = 8'hA5;
      lat1 = 0;
      bus1.consumer_read_address[2] = 8'h3C;
      bus1.consumer_read_valid[2]   = 1'b1;
      tick();
      n_cmp++; if (bus1.mem_read_valid !== 1'b1 || bus1.mem_read_address[0] !== 8'h3C || bus1.consumer_read_ready !== 4'b0000) begin n_fail++; $display("FAIL rd_grant: got v=%b a=%h r=%b want v=1 a=3c r=0000", bus1.mem_read_valid, bus1.mem_read_address[0], bus1.consumer_read_ready); end
      tick();
      n_cmp++; if (bus1.consumer_read_ready !== 4'b0100 || bus1.consumer_read_data[2] !== 8'hA5 || bus1.mem_read_valid !== 1'b0) begin n_fail++; $display("FAIL rd_return: got r=%b d=%h v=%b want r=0100 d=a5 v=0", bus1.consumer_read_ready, bus1.consumer_read_data[2], bus1.mem_read_valid); end
      for (int h = 0; h < 3; h++) begin
         tick();
         n_cmp++; if (bus1.consumer_read_ready !== 4'b0100 || bus1.consumer_read_data[2] !== 8'hA5) begin n_fail++; $display("FAIL rd_hold: got r=%b d=%h want r=0100 d=a5", bus1.consumer_read_ready, bus1.consumer_read_data[2]); end
      end
      bus1.consumer_read_valid[2] = 1'b0;
      tick();
      n_cmp++; if (bus1.consumer_read_ready !== 4'b0000) begin n_fail++; $display("FAIL rd_release: got %b want 0000", bus1.consumer_read_ready); end
   endtask

   task automatic test_single_write();
      int seen;
      bit got_rdy;
      seen = 0; got_rdy = 1'b0;
      lat1 = 3;
      exp_mem1[8'h10] = 8'h7E;
      bus1.consumer_write_address[1] = 8'h10;
      bus1.consumer_write_data[1]    = 8'h7E;
      bus1.consumer_write_valid[1]   = 1'b1;
      for (int cyc = 0; cyc < 20 && !got_rdy; cyc++) begin
         tick();
         if (bus1.consumer_write_ready[1]) got_rdy = 1'b1;
         else if (bus1.mem_write_valid[0]) begin
            seen++;
            n_cmp++; if (bus1.mem_write_address[0] !== 8'h10 || bus1.mem_write_data[0] !== 8'h7E) begin n_fail++; $display("FAIL wr_stable: got a=%h d=%h want a=10 d=7e", bus1.mem_write_address[0], bus1.mem_write_data[0]); end
            // Requester scribbles its inputs while claimed; the latched values must stand
            bus1.consumer_write_address[1] = 8'hFF;
            bus1.consumer_write_data[1]    = 8'h00;
         end
      end
      n_cmp++; if (got_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_timeout: got ready=%b want 1", got_rdy); end
      n_cmp++; if (seen != 4) begin n_fail++; $display("FAIL wr_valid_cycles: got %0d want 4", seen); end
      n_cmp++; if (bus1.mem_write_valid !== 1'b0) begin n_fail++; $display("FAIL wr_valid_drop: got %b want 0", bus1.mem_write_valid); end
      tick();
      n_cmp++; if (bus1.consumer_write_ready !== 4'b0010) begin n_fail++; $display("FAIL wr_hold: got %b want 0010", bus1.consumer_write_ready); end
      bus1.consumer_write_valid[1] = 1'b0;
      tick();
      n_cmp++; if (bus1.consumer_write_ready !== 4'b0000) begin n_fail++; $display("FAIL wr_release: got %b want 0000", bus1.consumer_write_ready); end
      n_cmp++; if (phys_mem1[8'h10] !== exp_mem1[8'h10]) begin n_fail++; $display("FAIL wr_mem: got %h want %h", phys_mem1[8'h10], exp_mem1[8'h10]); end
   endtask

   task automatic test_round_robin();
      logic [3:0] pending;
      logic [7:0] addr [4];
      int got [$];
      int want1 [4] = '{0, 1, 2, 3};
      int want2 [2] = '{0, 3};
      reset = 1'b0;
      tick();
      reset = 1'b1;
      lat1 = -1;
      for (int i = 0; i < 4; i++) begin
         addr[i] = 8'(($urandom_range(0, 63) << 2) | i);
         bus1.consumer_read_address[i] = addr[i];
      end
      pending = 4'b1111;
      bus1.consumer_read_valid = pending;
      for (int cyc = 0; cyc < 200 && pending != 4'b0000; cyc++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            if (pending[i] && bus1.consumer_read_ready[i]) begin
               n_cmp++; if (bus1.consumer_read_data[i] !== exp_mem1[addr[i]]) begin n_fail++; $display("FAIL rr_data c%0d: got %h want %h", i, bus1.consumer_read_data[i], exp_mem1[addr[i]]); end
               got.push_back(i);
               pending[i] = 1'b0;
               bus1.consumer_read_valid[i] = 1'b0;
            end
         end
      end
      n_cmp++; if (got.size() != 4) begin n_fail++; $display("FAIL rr_count: got %0d want 4", got.size()); end
      for (int k = 0; k < 4 && k < got.size(); k++) begin
         n_cmp++; if (got[k] != want1[k]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, got[k], want1[k]); end
      end
      tick();
      got.delete();
      pending = 4'b1001;
      bus1.consumer_read_valid = pending;
      for (int cyc = 0; cyc < 200 && pending != 4'b0000; cyc++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            if (pending[i] && bus1.consumer_read_ready[i]) begin
               got.push_back(i);
               pending[i] = 1'b0;
               bus1.consumer_read_valid[i] = 1'b0;
            end
         end
      end
      n_cmp++; if (got.size() != 2) begin n_fail++; $display("FAIL rr2_count: got %0d want 2", got.size()); end
      for (int k = 0; k < 2 && k < got.size(); k++) begin
         n_cmp++; if (got[k] != want2[k]) begin n_fail++; $display("FAIL rr2_order[%0d]: got %0d want %0d", k, got[k], want2[k]); end
      end
      tick();
   endtask

   task automatic test_two_channels();
      logic [3:0] pending;
      logic [7:0] addr [4];
      reset = 1'b0;
      tick();
      reset = 1'b1;
      lat2 = 100;
      for (int i = 0; i < 4; i++) begin
         addr[i] = 8'(($urandom_range(0, 63) << 2) | i);
         bus2.consumer_read_address[i] = addr[i];
      end
      pending = 4'b1111;
      bus2.consumer_read_valid = pending;
      tick();
      n_cmp++; if (bus2.mem_read_valid !== 2'b11) begin n_fail++; $display("FAIL ch2_both_valid: got %b want 11", bus2.mem_read_valid); end
      n_cmp++; if (bus2.mem_read_address[0] !== addr[0] || bus2.mem_read_address[1] !== addr[1]) begin n_fail++; $display("FAIL ch2_owners: got %h/%h want %h/%h", bus2.mem_read_address[0], bus2.mem_read_address[1], addr[0], addr[1]); end
      lat2 = -1;
      for (int cyc = 0; cyc < 200 && pending != 4'b0000; cyc++) begin
         tick();
         if (bus2.mem_read_valid == 2'b11) begin
            n_cmp++; if (bus2.mem_read_address[0][1:0] == bus2.mem_read_address[1][1:0]) begin n_fail++; $display("FAIL ch2_exclusive: both channels on consumer %0d", bus2.mem_read_address[0][1:0]); end
         end
         for (int i = 0; i < 4; i++) begin
            if (pending[i] && bus2.consumer_read_ready[i]) begin
               n_cmp++; if (bus2.consumer_read_data[i] !== exp_mem2[addr[i]]) begin n_fail++; $display("FAIL ch2_data c%0d: got %h want %h", i, bus2.consumer_read_data[i], exp_mem2[addr[i]]); end
               pending[i] = 1'b0;
               bus2.consumer_read_valid[i] = 1'b0;
            end
         end
      end
      n_cmp++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL ch2_timeout: pending %b want 0000", pending); end
      tick();
   endtask

   task automatic test_read_write_same();
      bit wr_early, done;
      logic [7:0] wd;
      wr_early = 1'b0; done = 1'b0;
      wd = 8'($urandom);
      lat1 = -1;
      exp_mem1[8'h48] = wd;
      bus1.consumer_read_address[0]  = 8'h44;
      bus1.consumer_write_address[0] = 8'h48;
      bus1.consumer_write_data[0]    = wd;
      bus1.consumer_read_valid[0]    = 1'b1;
      bus1.consumer_write_valid[0]   = 1'b1;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         tick();
         if (bus1.mem_write_valid[0]) wr_early = 1'b1;
         if (bus1.consumer_read_ready[0]) done = 1'b1;
      end
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL rw_read_timeout: got %b want 1", done); end
      n_cmp++; if (bus1.consumer_read_data[0] !== exp_mem1[8'h44]) begin n_fail++; $display("FAIL rw_read_data: got %h want %h", bus1.consumer_read_data[0], exp_mem1[8'h44]); end
      n_cmp++; if (bus1.consumer_write_ready[0] !== 1'b0) begin n_fail++; $display("FAIL rw_write_before_read: got %b want 0", bus1.consumer_write_ready[0]); end
      tick();
      n_cmp++; if (bus1.mem_write_valid !== 1'b0) begin n_fail++; $display("FAIL rw_write_during_relay: got %b want 0", bus1.mem_write_valid); end
      bus1.consumer_read_valid[0] = 1'b0;
      tick();
      n_cmp++; if (bus1.consumer_read_ready[0] !== 1'b0 || bus1.mem_write_valid !== 1'b0) begin n_fail++; $display("FAIL rw_release: got r=%b wv=%b want 0/0", bus1.consumer_read_ready[0], bus1.mem_write_valid); end
      tick();
      n_cmp++; if (bus1.mem_write_valid !== 1'b1 || bus1.mem_write_address[0] !== 8'h48) begin n_fail++; $display("FAIL rw_write_grant: got v=%b a=%h want v=1 a=48", bus1.mem_write_valid, bus1.mem_write_address[0]); end
      done = 1'b0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         if (bus1.consumer_write_ready[0]) done = 1'b1;
         else tick();
      end
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL rw_write_timeout: got %b want 1", done); end
      n_cmp++; if (wr_early !== 1'b0) begin n_fail++; $display("FAIL rw_order: write issued before read, got %b want 0", wr_early); end
      bus1.consumer_write_valid[0] = 1'b0;
      tick();
      n_cmp++; if (phys_mem1[8'h48] !== exp_mem1[8'h48]) begin n_fail++; $display("FAIL rw_mem: got %h want %h", phys_mem1[8'h48], exp_mem1[8'h48]); end
   endtask

   task automatic test_random_traffic();
      bit         act [4];
      bit         wr  [4];
      logic [7:0] a   [4];
      logic [7:0] d   [4];
      int         done_cnt, bad;
      int         owner [2];
      done_cnt = 0;
      lat2 = -1;
      for (int i = 0; i < 4; i++) act[i] = 1'b0;
      for (int cyc = 0; cyc < 3000 && done_cnt < 80; cyc++) begin
         tick();
         for (int c = 0; c < 2; c++) begin
            owner[c] = -1;
            if (bus2.mem_read_valid[c])  owner[c] = int'(bus2.mem_read_address[c][1:0]);
            if (bus2.mem_write_valid[c]) owner[c] = int'(bus2.mem_write_address[c][1:0]);
         end
         if (owner[0] >= 0 && owner[1] >= 0) begin
            n_cmp++; if (owner[0] == owner[1]) begin n_fail++; $display("FAIL rnd_exclusive: both channels on consumer %0d", owner[0]); end
         end
         for (int i = 0; i < 4; i++) begin
            if (act[i]) begin
               if (!wr[i] && bus2.consumer_read_ready[i]) begin
                  n_cmp++; if (bus2.consumer_read_data[i] !== exp_mem2[a[i]]) begin n_fail++; $display("FAIL rnd_read c%0d a=%h: got %h want %h", i, a[i], bus2.consumer_read_data[i], exp_mem2[a[i]]); end
                  bus2.consumer_read_valid[i] = 1'b0;
                  act[i] = 1'b0;
                  done_cnt++;
               end else if (wr[i] && bus2.consumer_write_ready[i]) begin
                  exp_mem2[a[i]] = d[i];
                  bus2.consumer_write_valid[i] = 1'b0;
                  act[i] = 1'b0;
                  done_cnt++;
               end
            end else if (!bus2.consumer_read_ready[i] && !bus2.consumer_write_ready[i] &&
                         $urandom_range(0, 2) == 0) begin
               act[i] = 1'b1;
               wr[i]  = ($urandom_range(0, 1) == 1);
               a[i]   = 8'(($urandom_range(0, 15) << 2) | i);
               d[i]   = 8'($urandom);
               if (wr[i]) begin
                  bus2.consumer_write_address[i] = a[i];
                  bus2.consumer_write_data[i]    = d[i];
                  bus2.consumer_write_valid[i]   = 1'b1;
               end else begin
                  bus2.consumer_read_address[i] = a[i];
                  bus2.consumer_read_valid[i]   = 1'b1;
               end
            end
         end
      end
      n_cmp++; if (done_cnt < 80) begin n_fail++; $display("FAIL rnd_progress: got %0d want 80 transactions", done_cnt); end
      bus2.consumer_read_valid  = '0;
      bus2.consumer_write_valid = '0;
      tick(); tick();
      bad = 0;
      for (int k = 0; k < 256; k++) if (phys_mem2[k] !== exp_mem2[k]) bad++;
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rnd_mem_image: got %0d differing bytes want 0", bad); end
   endtask

   initial begin
      reset = 1'b0;
      for (int k = 0; k < 256; k++) begin
         phys_mem1[k] = 8'($urandom);
         exp_mem1[k]  = phys_mem1[k];
         phys_mem2[k] = 8'($urandom);
         exp_mem2[k]  = phys_mem2[k];
      end
      bus1.consumer_read_valid  = '0;
      bus1.consumer_write_valid = '0;
      bus2.consumer_read_valid  = '0;
      bus2.consumer_write_valid = '0;
      for (int i = 0; i < NC; i++) begin
         bus1.consumer_read_address[i]  = '0;
         bus1.consumer_write_address[i] = '0;
         bus1.consumer_write_data[i]    = '0;
         bus2.consumer_read_address[i]  = '0;
         bus2.consumer_write_address[i] = '0;
         bus2.consumer_write_data[i]    = '0;
      end
      test_reset();
      test_single_read();
      test_single_write();
      test_round_robin();
      test_two_channels();
      test_read_write_same();
      test_random_traffic();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
